// File: rtl/hilo_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_hazard_ctrl
//   ID-stage hazard and scheduling controller: load-use detection, branch
//   flush, and HI/LO multi-cycle resource tracking for MULT/DIV-class ops.
//   Optional macro HILO_STALL_COUNT_EN builds a saturating 16-bit stall
//   statistics counter on oStallCycles; otherwise oStallCycles is tied to 0.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hilo_hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic        EXMemRead,
  input  logic [4:0]  EXRegWriteAddr,
  input  logic        BranchTaken,
  output logic        oPCWrite,
  output logic        oIFIDWrite,
  output logic        oIFIDFlush,
  output logic        oIDEXBubble,
  output logic        oHiLoBusy,
  output logic        oHiLoWrite,
  output logic [15:0] oStallCycles
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;

  logic is_mul;
  logic is_div;
  logic is_hilo_user;
  logic loaduse;
  logic hlstall;
  logic stall;
  logic issue;
  logic [3:0] cnt;

  // rd and shamt fields play no part in hazard decisions
  logic unused_fields;
  assign unused_fields = ^Instruction[15:6];

  assign opcode = Instruction[31:26];
  assign funct  = Instruction[5:0];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];

  // Instruction class decode for HI/LO ownership
  always_comb begin
    is_mul       = 1'b0;
    is_div       = 1'b0;
    is_hilo_user = 1'b0;
    if (opcode == OP_SPECIAL) begin
      is_mul = (funct == 6'h18) || (funct == 6'h19);
      is_div = (funct == 6'h1A) || (funct == 6'h1B);
      is_hilo_user = (funct[5:2] == 4'b0100);   // MFHI/MTHI/MFLO/MTLO
    end else if (opcode == OP_SPECIAL2) begin
      is_mul = (funct == 6'h00) || (funct == 6'h04);
    end
    is_hilo_user = is_hilo_user | is_mul | is_div;
  end

  assign loaduse = EXMemRead && (EXRegWriteAddr != 5'd0) &&
                   ((EXRegWriteAddr == rs) || (EXRegWriteAddr == rt));
  assign hlstall = oHiLoBusy && is_hilo_user;
  assign stall   = loaduse || hlstall;

  // Pipeline control: a taken branch overrides any stall
  always_comb begin
    oPCWrite    = 1'b1;
    oIFIDWrite  = 1'b1;
    oIFIDFlush  = 1'b0;
    oIDEXBubble = 1'b0;
    if (BranchTaken) begin
      oIFIDFlush  = 1'b1;
      oIDEXBubble = 1'b1;
    end else if (stall) begin
      oPCWrite    = 1'b0;
      oIFIDWrite  = 1'b0;
      oIDEXBubble = 1'b1;
    end
  end

  // Only a MUL/DIV that actually moves into EX claims HI/LO
  assign issue = (is_mul || is_div) && !oIDEXBubble;

  // HI/LO busy countdown; hlstall guarantees no issue while busy
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= 4'd0;
    end else if (issue) begin
      cnt <= is_div ? DIV_CNT : MUL_CNT;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign oHiLoBusy  = (cnt != 4'd0);
  assign oHiLoWrite = (cnt == 4'd1);

`ifdef HILO_STALL_COUNT_EN
  logic [15:0] stall_cycles;

  // Saturating count of cycles lost to stalls (flush cycles excluded)
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_cycles <= 16'd0;
    end else if (stall && !BranchTaken && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

  assign oStallCycles = stall_cycles;
`else
  assign oStallCycles = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hilo_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_hazard_ctrl
//   Self-checking bench: directed vector table, multi-cycle hand sequences,
//   and randomized traffic against a cycle-stamp reference model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hilo_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;
`ifdef HILO_STALL_COUNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        Clk;
  logic        Reset;
  logic [31:0] Instruction;
  logic        EXMemRead;
  logic [4:0]  EXRegWriteAddr;
  logic        BranchTaken;
  logic        oPCWrite;
  logic        oIFIDWrite;
  logic        oIFIDFlush;
  logic        oIDEXBubble;
  logic        oHiLoBusy;
  logic        oHiLoWrite;
  logic [15:0] oStallCycles;

  hilo_hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .Clk(Clk), .Reset(Reset), .Instruction(Instruction),
    .EXMemRead(EXMemRead), .EXRegWriteAddr(EXRegWriteAddr),
    .BranchTaken(BranchTaken), .oPCWrite(oPCWrite), .oIFIDWrite(oIFIDWrite),
    .oIFIDFlush(oIFIDFlush), .oIDEXBubble(oIDEXBubble),
    .oHiLoBusy(oHiLoBusy), .oHiLoWrite(oHiLoWrite),
    .oStallCycles(oStallCycles)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] fn);
    return {op, rs, rt, 5'd3, 5'd0, fn};
  endfunction

  // 0: other, 1: MUL class, 2: DIV class, 3: HI/LO move
  function automatic int op_class(input logic [31:0] i);
    logic [5:0] op;
    logic [5:0] fn;
    op = i[31:26];
    fn = i[5:0];
    if (op == 6'h00 && (fn == 6'h18 || fn == 6'h19)) return 1;
    if (op == 6'h1C && (fn == 6'h00 || fn == 6'h04)) return 1;
    if (op == 6'h00 && (fn == 6'h1A || fn == 6'h1B)) return 2;
    if (op == 6'h00 && fn >= 6'h10 && fn <= 6'h13) return 3;
    return 0;
  endfunction

  // Returns {pcw, ifidw, flush, bubble, stall, issue}
  function automatic logic [5:0] exp_ctl(input logic [31:0] i, input logic mr,
                                         input logic [4:0] a, input logic br, input logic busy);
    int  cls;
    bit  lu, st, pcw, ifw, fl, bub;
    cls = op_class(i);
    lu  = mr && a != 0 && (a == i[25:21] || a == i[20:16]);
    st  = lu || (busy && cls != 0);
    if (br)      begin pcw = 1; ifw = 1; fl = 1; bub = 1; end
    else if (st) begin pcw = 0; ifw = 0; fl = 0; bub = 1; end
    else         begin pcw = 1; ifw = 1; fl = 0; bub = 0; end
    return {pcw, ifw, fl, bub, st, (cls == 1 || cls == 2) && !bub};
  endfunction

  // Reference model: HI/LO is free from cycle stamp free_at onward
  int cyc, free_at, m_stalls;
  logic m_busy, m_write;
  logic [5:0] m_ctl;
  assign m_busy  = (cyc < free_at);
  assign m_write = (cyc == free_at - 1);

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cyc <= 0; free_at <= 0; m_stalls <= 0;
    end else begin
      m_ctl = exp_ctl(Instruction, EXMemRead, EXRegWriteAddr, BranchTaken, m_busy);
      if (m_ctl[0])
        free_at <= cyc + 1 + ((op_class(Instruction) == 2) ? DIV_LAT : MUL_LAT);
      if (m_ctl[1] && !BranchTaken && m_stalls < 65535) m_stalls <= m_stalls + 1;
      cyc <= cyc + 1;
    end
  end

  task automatic drive(input logic [31:0] i, input logic mr, input logic [4:0] a, input logic br);
    Instruction = i; EXMemRead = mr; EXRegWriteAddr = a; BranchTaken = br;
  endtask

  typedef struct packed {
    logic [31:0] instr;
    logic        mr;
    logic [4:0]  addr;
    logic        br;
    logic [3:0]  exp;   // {pcw, ifidw, flush, bubble}
  } vec_t;

  localparam logic [31:0] NOP = 32'h0;
  logic [31:0] MULT, DIV, MFLO, MTHI, MFHI;
  vec_t vecs[9];

  initial begin
    MULT = rtype(6'h00, 5'd1, 5'd2, 6'h18);
    DIV  = rtype(6'h00, 5'd1, 5'd2, 6'h1A);
    MFLO = rtype(6'h00, 5'd0, 5'd0, 6'h12);
    MTHI = rtype(6'h00, 5'd4, 5'd0, 6'h11);
    MFHI = rtype(6'h00, 5'd0, 5'd0, 6'h10);

    vecs[0] = '{NOP, 1'b0, 5'd0, 1'b0, 4'b1100};
    vecs[1] = '{rtype(6'h00, 5'd8, 5'd10, 6'h20), 1'b1, 5'd8, 1'b0, 4'b0001};
    vecs[2] = '{rtype(6'h00, 5'd10, 5'd8, 6'h20), 1'b1, 5'd8, 1'b0, 4'b0001};
    vecs[3] = '{rtype(6'h00, 5'd0, 5'd0, 6'h20), 1'b1, 5'd0, 1'b0, 4'b1100};
    vecs[4] = '{rtype(6'h00, 5'd8, 5'd10, 6'h20), 1'b0, 5'd8, 1'b0, 4'b1100};
    vecs[5] = '{NOP, 1'b0, 5'd0, 1'b1, 4'b1111};
    vecs[6] = '{rtype(6'h00, 5'd8, 5'd10, 6'h20), 1'b1, 5'd8, 1'b1, 4'b1111};
    vecs[7] = '{MFHI, 1'b0, 5'd0, 1'b0, 4'b1100};
    vecs[8] = '{rtype(6'h00, 5'd9, 5'd2, 6'h18), 1'b1, 5'd9, 1'b0, 4'b0001};

    Reset = 1'b0;
    drive(NOP, 0, 0, 0);
    repeat (2) @(negedge Clk);
    #1;
    chk("reset_busy", oHiLoBusy, 0);
    chk("reset_write", oHiLoWrite, 0);
    chk("reset_stallcnt", oStallCycles, 0);
    Reset = 1'b1;

    // Directed combinational vectors, each from a clean HI/LO state
    for (int i = 0; i < 9; i++) begin
      @(negedge Clk);
      drive(vecs[i].instr, vecs[i].mr, vecs[i].addr, vecs[i].br);
      #1;
      chk($sformatf("vec%0d_ctl", i), {oPCWrite, oIFIDWrite, oIFIDFlush, oIDEXBubble}, vecs[i].exp);
      drive(NOP, 0, 0, 0);
      Reset = 1'b0; #1; Reset = 1'b1;
    end

    // MULT issues, MFLO waits through the 4 busy cycles
    @(negedge Clk); drive(MULT, 0, 0, 0); #1;
    chk("mult_issue_bubble", oIDEXBubble, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk); drive(MFLO, 0, 0, 0); #1;
      chk($sformatf("mult_busy_c%0d", k), oHiLoBusy, 1);
      chk($sformatf("mult_write_c%0d", k), oHiLoWrite, (k == 4));
      chk($sformatf("mflo_stall_c%0d", k), {oPCWrite, oIDEXBubble}, 2'b01);
    end
    @(negedge Clk); #1;
    chk("mflo_go_busy", oHiLoBusy, 0);
    chk("mflo_go_ctl", {oPCWrite, oIDEXBubble}, 2'b10);

    // Back-to-back DIVs: second one waits out the first
    @(negedge Clk); drive(DIV, 0, 0, 0); #1;
    chk("div1_issue", oIDEXBubble, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk); #1;
      chk($sformatf("div2_stall_c%0d", k), oIDEXBubble, 1);
      chk($sformatf("div1_write_c%0d", k), oHiLoWrite, (k == 8));
    end
    @(negedge Clk); #1;
    chk("div2_issue", {oHiLoBusy, oIDEXBubble}, 2'b00);
    for (int k = 10; k <= 17; k++) begin
      @(negedge Clk); drive(NOP, 0, 0, 0); #1;
      chk($sformatf("div2_busy_c%0d", k), oHiLoBusy, 1);
      chk($sformatf("div2_write_c%0d", k), oHiLoWrite, (k == 17));
    end
    @(negedge Clk); #1;
    chk("div2_done", oHiLoBusy, 0);

    // Branch beats load-use and a ready MULT; MULT must not issue
    @(negedge Clk); drive(rtype(6'h00, 5'd8, 5'd2, 6'h18), 1, 5'd8, 1); #1;
    chk("branch_ctl", {oPCWrite, oIFIDWrite, oIFIDFlush, oIDEXBubble}, 4'b1111);
    @(negedge Clk); drive(NOP, 0, 0, 0); #1;
    chk("branch_no_issue", oHiLoBusy, 0);

    // Asynchronous reset in the middle of a DIV (count at 5)
    @(negedge Clk); drive(DIV, 0, 0, 0);
    @(negedge Clk); drive(NOP, 0, 0, 0);
    repeat (3) @(negedge Clk);
    #1;
    chk("midop_busy_before", oHiLoBusy, 1);
    Reset = 1'b0; #1;
    chk("midop_busy", oHiLoBusy, 0);
    chk("midop_write", oHiLoWrite, 0);
    chk("midop_pcw", oPCWrite, 1);
    #1; Reset = 1'b1;
    drive(MTHI, 0, 0, 0); #1;
    chk("mthi_after_reset", {oPCWrite, oIDEXBubble}, 2'b10);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [5:0]  e;
      logic [4:0]  ra, rb;
      ra = 5'($urandom_range(0, 3));
      rb = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 11))
        0:  ins = rtype(6'h00, ra, rb, 6'h18);
        1:  ins = rtype(6'h00, ra, rb, 6'h19);
        2:  ins = rtype(6'h1C, ra, rb, 6'h00);
        3:  ins = rtype(6'h1C, ra, rb, 6'h04);
        4:  ins = rtype(6'h00, ra, rb, 6'h1A);
        5:  ins = rtype(6'h00, ra, rb, 6'h1B);
        6:  ins = rtype(6'h00, ra, rb, 6'h10);
        7:  ins = rtype(6'h00, ra, rb, 6'h11);
        8:  ins = rtype(6'h00, ra, rb, 6'h12);
        9:  ins = rtype(6'h00, ra, rb, 6'h13);
        10: ins = rtype(6'h00, ra, rb, 6'h20);
        default: ins = rtype(6'h1C, ra, rb, 6'h02);
      endcase
      @(negedge Clk);
      drive(ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0));
      #1;
      e = exp_ctl(Instruction, EXMemRead, EXRegWriteAddr, BranchTaken, m_busy);
      chk($sformatf("rnd%0d_ctl", n), {oPCWrite, oIFIDWrite, oIFIDFlush, oIDEXBubble}, e[5:2]);
      chk($sformatf("rnd%0d_busy", n), oHiLoBusy, m_busy);
      chk($sformatf("rnd%0d_write", n), oHiLoWrite, m_write);
      chk($sformatf("rnd%0d_stallcnt", n), oStallCycles, STALL_EN ? 32'(m_stalls) : 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
